packed_macc_seq: RTL and testbench
==================================

Name: packed_macc_seq

Overview:
- Sequencer for the packed dual-lane INT8 MACC slice.
- Computes two dot products that share one input vector: sum(x*wj) and sum(x*wk).
- Streams elements into the slice and feeds the packed accumulator back through the slice's C port.
- Waits out the DSP pipeline latency, then unpacks the two lanes with borrow correction.
- Sits between the layer's weight/activation fetch logic and its output writeback.

Parameters:
- WIDTH, 8: operand width; legal range 1..8.
- SIGN, 1: 1 = two's-complement operands and results; 0 = unsigned.
- DSP_LAT, 3: cycles from operands presented to P valid at the slice; legal range 1..15.
- LEN_W, 10: width of the vector-length field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a new dot product; honoured only in IDLE.
- len  in  LEN_W  element count, sampled when start is accepted.
- busy  out  1  high in every state other than IDLE.
- in_valid  in  1  element available.
- in_ready  out  1  controller accepts an element this cycle.
- in_x  in  WIDTH  shared input element.
- in_wj  in  WIDTH  j-lane weight.
- in_wk  in  WIDTH  k-lane weight.
- mac_input_i  out  WIDTH  registered slice operand.
- mac_weight_j  out  WIDTH  registered slice operand.
- mac_weight_k  out  WIDTH  registered slice operand.
- mac_ji_accum  out  24+WIDTH  packed accumulator, upper field.
- mac_ki_accum  out  24-WIDTH  packed accumulator, lower field.
- mac_ji  in  24+WIDTH  slice P, upper field.
- mac_ki  in  24-WIDTH  slice P, lower field.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_j  out  24+WIDTH  corrected j-lane sum.
- res_k  out  24-WIDTH  k-lane sum.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; accumulator 0; element counter 0; wait counter 0.
- FSM states: IDLE, FETCH, WAIT, DONE.
- IDLE:
  - On start with len != 0: clear the accumulator, load the counter with len, go to FETCH.
  - On start with len == 0: clear the accumulator, go directly to DONE.
- FETCH:
  - in_ready = 1.
  - On handshake (in_valid & in_ready): register in_x, in_wj, in_wk onto the mac_* operand outputs; load the wait counter with DSP_LAT; go to WAIT.
- WAIT:
  - in_ready = 0. Operand and accumulator outputs are held stable.
  - At the edge that lands exactly DSP_LAT cycles after the handshake edge, capture {mac_ji, mac_ki} into the accumulator and decrement the element counter.
  - If the counter reaches 0, go to DONE; otherwise go to FETCH.
  - Per-element throughput: DSP_LAT+1 cycles with in_valid held high.
- mac_ji_accum and mac_ki_accum always present the accumulator register.
- DONE:
  - res_valid = 1. res_j and res_k are stable until the res_ready handshake, then go to IDLE.
  - Start pulses in DONE are ignored.
- Unpack, SIGN=1:
  - res_k = lower field, interpreted as signed.
  - res_j = upper field + lower[23-WIDTH] (borrow correction), computed modulo 2^(24+WIDTH).
- Unpack, SIGN=0: res_j = upper field; res_k = lower field; no correction.
- Lane range: the k-lane result is exact only if every partial sum fits 24-WIDTH bits (signed range for SIGN=1). Out of range wraps modulo 2^(24-WIDTH) and corrupts res_j by ±1. This is the caller's responsibility; no flag is raised.
- start while busy: ignored; no state or output change.
- in_valid outside FETCH: ignored; the element is not consumed.
- Reset mid-operation: immediate return to IDLE; partial result discarded; res_valid = 0.

Test Plan:
- Single element, len=1, in_wj=50, in_wk=-20, in_x=3, SIGN=1:
  - Raw P fields: upper 149, lower 0xFFC4.
  - Required: res_j=150, res_k=-60.
  - res_valid rises DSP_LAT+1 cycles after the handshake edge.
- Dot product, len=3, x={3,-2,5}, wj={1,2,3}, wk={-4,7,0}:
  - Required: res_j=14, res_k=-26.
  - Exactly 3 input handshakes; in_ready low throughout each WAIT.
- len=0 start: DONE on the next edge; res_j=0, res_k=0; no in_ready pulse.
- Backpressure and stray starts:
  - Hold res_ready=0 for 10 cycles: res_valid and data stay stable.
  - A start pulse during DONE has no effect.
  - Asserting res_ready returns the FSM to IDLE in 1 cycle.
- Input stall: drop in_valid for 5 cycles mid-vector. The accumulator is unchanged and the final result equals the no-stall result.
- Async reset mid-operation: assert rst_n=0 during WAIT of element 2 of len=4. All outputs go to 0 immediately; the next run with len=1, wj=-128, wk=-128, x=-128 gives res_j=16384, res_k=16384.

Source files
------------

// File: rtl/packed_macc_seq.sv
// packed_macc_seq: sequencer for the packed dual-lane INT8 MACC slice.
// Streams (x, wj, wk) elements into the slice, feeds the packed accumulator
// back through the C port, waits out the slice latency per element, then
// unpacks the two lanes (with borrow correction for signed data).
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, len                  begin a dot product of len elements (IDLE only)
//   busy                        high whenever not IDLE
//   in_valid/in_ready           element handshake; in_x, in_wj, in_wk payload
//   mac_input_i/weight_j/_k     registered slice operands
//   mac_ji_accum/mac_ki_accum   packed accumulator presented to slice C
//   mac_ji/mac_ki               slice P (upper/lower fields)
//   res_valid/res_ready         result handshake; res_j, res_k lane sums
module packed_macc_seq #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SIGN    = 1,
    parameter int unsigned DSP_LAT = 3,
    parameter int unsigned LEN_W   = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_x,
    input  logic [WIDTH-1:0]      in_wj,
    input  logic [WIDTH-1:0]      in_wk,
    output logic [WIDTH-1:0]      mac_input_i,
    output logic [WIDTH-1:0]      mac_weight_j,
    output logic [WIDTH-1:0]      mac_weight_k,
    output logic [24+WIDTH-1:0]   mac_ji_accum,
    output logic [24-WIDTH-1:0]   mac_ki_accum,
    input  logic [24+WIDTH-1:0]   mac_ji,
    input  logic [24-WIDTH-1:0]   mac_ki,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [24+WIDTH-1:0]   res_j,
    output logic [24-WIDTH-1:0]   res_k
);

    localparam int unsigned UW     = 24 + WIDTH;
    localparam int unsigned LW     = 24 - WIDTH;
    localparam int unsigned WAIT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
    logic [UW-1:0]       acc_hi_q, acc_hi_d;
    logic [LW-1:0]       acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]    op_x_q, op_x_d;
    logic [WIDTH-1:0]    op_j_q, op_j_d;
    logic [WIDTH-1:0]    op_k_q, op_k_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                res_valid_q, res_valid_d;
    logic [UW-1:0]       res_j_q, res_j_d;
    logic [LW-1:0]       res_k_q, res_k_d;
    logic [UW-1:0]       unpack_j;

    // Signed lanes: a negative lower field borrowed one from the upper field.
    always_comb begin
        unpack_j = acc_hi_q;
        if (SIGN != 0) begin
            unpack_j = acc_hi_q + UW'(acc_lo_q[LW-1]);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        op_x_d      = op_x_q;
        op_j_d      = op_j_q;
        op_k_d      = op_k_q;
        res_valid_d = res_valid_q;
        res_j_d     = res_j_q;
        res_k_d     = res_k_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_hi_d = '0;
                    acc_lo_d = '0;
                    if (len != '0) begin
                        cnt_d   = len;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (in_valid && in_ready_q) begin
                    op_x_d  = in_x;
                    op_j_d  = in_wj;
                    op_k_d  = in_wk;
                    wcnt_d  = WAIT_W'(DSP_LAT);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // wcnt == 1 marks the edge DSP_LAT cycles after the handshake.
                if (wcnt_q == WAIT_W'(1)) begin
                    acc_hi_d = mac_ji;
                    acc_lo_d = mac_ki;
                    cnt_d    = cnt_q - LEN_W'(1);
                    wcnt_d   = '0;
                    state_d  = (cnt_q == LEN_W'(1)) ? S_DONE : S_FETCH;
                end else begin
                    wcnt_d = wcnt_q - WAIT_W'(1);
                end
            end
            S_DONE: begin
                // First DONE cycle registers the unpacked result.
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_j_d     = unpack_j;
                    res_k_d     = acc_lo_q;
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_FETCH);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wcnt_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            op_x_q      <= '0;
            op_j_q      <= '0;
            op_k_q      <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_j_q     <= '0;
            res_k_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wcnt_q      <= wcnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            op_x_q      <= op_x_d;
            op_j_q      <= op_j_d;
            op_k_q      <= op_k_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            res_j_q     <= res_j_d;
            res_k_q     <= res_k_d;
        end
    end

    assign busy         = busy_q;
    assign in_ready     = in_ready_q;
    assign mac_input_i  = op_x_q;
    assign mac_weight_j = op_j_q;
    assign mac_weight_k = op_k_q;
    assign mac_ji_accum = acc_hi_q;
    assign mac_ki_accum = acc_lo_q;
    assign res_valid    = res_valid_q;
    assign res_j        = res_j_q;
    assign res_k        = res_k_q;

endmodule

// File: tb/tb_packed_macc_seq.sv
// Bench for packed_macc_seq: emulates the packed MACC slice, expects plain
// dot-product sums from the element lists, plus hand-computed literals.
module tb_packed_macc_seq;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned DSP_LAT = 3;
    localparam int unsigned LEN_W   = 10;
    localparam int unsigned UW      = 24 + WIDTH;
    localparam int unsigned LW      = 24 - WIDTH;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_x, in_wj, in_wk;
    logic [WIDTH-1:0]  mac_input_i, mac_weight_j, mac_weight_k;
    logic [UW-1:0]     mac_ji_accum, mac_ji;
    logic [LW-1:0]     mac_ki_accum, mac_ki;
    logic              res_valid;
    logic              res_ready;
    logic [UW-1:0]     res_j;
    logic [LW-1:0]     res_k;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_count = 0;
    int ready_seen = 0;
    int hs_cyc = 0;
    longint exp_j = 0;
    longint exp_k = 0;

    packed_macc_seq #(
        .WIDTH(WIDTH), .SIGN(1), .DSP_LAT(DSP_LAT), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_wj(in_wj), .in_wk(in_wk),
        .mac_input_i(mac_input_i), .mac_weight_j(mac_weight_j),
        .mac_weight_k(mac_weight_k),
        .mac_ji_accum(mac_ji_accum), .mac_ki_accum(mac_ki_accum),
        .mac_ji(mac_ji), .mac_ki(mac_ki),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_j(res_j), .res_k(res_k)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slice emulation: P = C + x*(wj*2^16 + wk), valid DSP_LAT-1 edges after operands.
    function automatic logic [47:0] slice_f(logic [7:0] x, logic [7:0] wj,
                                            logic [7:0] wk, logic [47:0] c);
        longint xs, js, ks, r;
        xs = longint'($signed(x));
        js = longint'($signed(wj));
        ks = longint'($signed(wk));
        r  = longint'(c) + xs * js * 65536 + xs * ks;
        return r[47:0];
    endfunction

    logic [47:0] p0, p1;
    always @(posedge clk) begin
        p0 <= slice_f(mac_input_i, mac_weight_j, mac_weight_k, {mac_ji_accum, mac_ki_accum});
        p1 <= p0;
    end
    assign mac_ji = p1[47:16];
    assign mac_ki = p1[15:0];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Continuous compare: results vs model, WAIT windows, operand registering.
    initial begin
        int wait_left;
        logic [7:0] hs_x, hs_j;
        wait_left = 0;
        hs_x = '0;
        hs_j = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_ready) ready_seen++;
                if (res_valid) begin
                    chk("res_j_model", longint'($signed(res_j)), exp_j);
                    chk("res_k_model", longint'($signed(res_k)), exp_k);
                end
                if (wait_left > 0) begin
                    chk("in_ready_low_in_wait", longint'(in_ready), 0);
                    if (wait_left == int'(DSP_LAT)) begin
                        chk("mac_input_i", longint'(mac_input_i), longint'(hs_x));
                        chk("mac_weight_j", longint'(mac_weight_j), longint'(hs_j));
                    end
                    wait_left--;
                end
                if (in_ready && in_valid) begin
                    hs_count++;
                    wait_left = int'(DSP_LAT);
                    hs_x = in_x;
                    hs_j = in_wj;
                end
            end else begin
                wait_left = 0;
            end
        end
    end

    task automatic pulse_start(input int n);
        @(posedge clk);
        #1 start = 1'b1;
        len = LEN_W'(n);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send(input int x, input int j, input int k, input bit stall);
        int t;
        logic [47:0] a0;
        if (stall) begin
            in_valid = 1'b0;
            t = 0;
            do begin @(negedge clk); t++; end while (!in_ready && t < 50);
            a0 = {mac_ji_accum, mac_ki_accum};
            repeat (5) @(negedge clk);
            chk("stall_in_ready", longint'(in_ready), 1);
            chk("stall_accum_held", longint'({mac_ji_accum, mac_ki_accum}), longint'(a0));
            @(posedge clk);
            #1;
        end
        in_x = WIDTH'(x);
        in_wj = WIDTH'(j);
        in_wk = WIDTH'(k);
        in_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!(in_ready && in_valid) && t < 50);
        chk("handshake_seen", longint'(in_ready), 1);
        @(posedge clk);
        #1 hs_cyc = cyc;
    endtask

    task automatic finish(input int exp_lat, input longint lit_j, input longint lit_k, input bit bp);
        int t;
        logic [UW-1:0] rj;
        logic [LW-1:0] rk;
        in_valid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!res_valid && t < 100);
        chk("res_valid_seen", longint'(res_valid), 1);
        if (exp_lat >= 0) chk("result_latency", longint'(cyc - hs_cyc), longint'(exp_lat));
        chk("lit_res_j", longint'($signed(res_j)), lit_j);
        chk("lit_res_k", longint'($signed(res_k)), lit_k);
        if (bp) begin
            rj = res_j;
            rk = res_k;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (i == 4) begin start = 1'b1; len = LEN_W'(1); end
                if (i == 5) start = 1'b0;
                chk("bp_valid_held", longint'(res_valid), 1);
                chk("bp_res_j_held", longint'(res_j), longint'(rj));
                chk("bp_res_k_held", longint'(res_k), longint'(rk));
            end
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        chk("idle_busy", longint'(busy), 0);
        chk("idle_res_valid", longint'(res_valid), 0);
        @(posedge clk);
        #1 chk("stays_idle", longint'(busy), 0);
    endtask

    task automatic expect_zero_outputs(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_in_ready"}, longint'(in_ready), 0);
        chk({tag, "_res_valid"}, longint'(res_valid), 0);
        chk({tag, "_mac_x"}, longint'(mac_input_i), 0);
        chk({tag, "_mac_wj"}, longint'(mac_weight_j), 0);
        chk({tag, "_mac_wk"}, longint'(mac_weight_k), 0);
        chk({tag, "_acc_hi"}, longint'(mac_ji_accum), 0);
        chk({tag, "_acc_lo"}, longint'(mac_ki_accum), 0);
        chk({tag, "_res_j"}, longint'(res_j), 0);
        chk({tag, "_res_k"}, longint'(res_k), 0);
    endtask

    // Reference dot products from element lists.
    function automatic void set_model(input int n, input int xs[8], input int js[8], input int ks[8]);
        exp_j = 0;
        exp_k = 0;
        for (int i = 0; i < n; i++) begin
            exp_j += longint'(xs[i]) * longint'(js[i]);
            exp_k += longint'(xs[i]) * longint'(ks[i]);
        end
    endfunction

    initial begin
        int xs[8], js[8], ks[8];
        int h0, r0, first_hs;
        rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
        in_x = '0; in_wj = '0; in_wk = '0; res_ready = 1'b0;
        #12;
        expect_zero_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single element: 3*(50, -20)
        xs = '{3, 0, 0, 0, 0, 0, 0, 0};
        js = '{50, 0, 0, 0, 0, 0, 0, 0};
        ks = '{-20, 0, 0, 0, 0, 0, 0, 0};
        set_model(1, xs, js, ks);
        pulse_start(1);
        send(3, 50, -20, 0);
        finish(int'(DSP_LAT) + 1, 150, -60, 0);
        chk("raw_upper", longint'(mac_ji_accum), 149);
        chk("raw_lower", longint'(mac_ki_accum), 16'hFFC4);

        // Three-element dot product, in_valid held high
        xs = '{3, -2, 5, 0, 0, 0, 0, 0};
        js = '{1, 2, 3, 0, 0, 0, 0, 0};
        ks = '{-4, 7, 0, 0, 0, 0, 0, 0};
        set_model(3, xs, js, ks);
        h0 = hs_count;
        pulse_start(3);
        send(3, 1, -4, 0);
        first_hs = hs_cyc;
        send(-2, 2, 7, 0);
        send(5, 3, 0, 0);
        chk("throughput", longint'(hs_cyc - first_hs), 2 * (longint'(DSP_LAT) + 1));
        finish(int'(DSP_LAT) + 1, 14, -26, 0);
        chk("len3_handshakes", longint'(hs_count - h0), 3);

        // Zero-length vector
        exp_j = 0;
        exp_k = 0;
        h0 = hs_count;
        r0 = ready_seen;
        pulse_start(0);
        chk("len0_busy", longint'(busy), 1);
        chk("len0_in_ready", longint'(in_ready), 0);
        finish(-1, 0, 0, 0);
        chk("len0_no_ready", longint'(ready_seen - r0), 0);
        chk("len0_no_handshake", longint'(hs_count - h0), 0);

        // Backpressure with a stray start in DONE
        xs = '{-7, 4, 0, 0, 0, 0, 0, 0};
        js = '{10, -3, 0, 0, 0, 0, 0, 0};
        ks = '{2, 5, 0, 0, 0, 0, 0, 0};
        set_model(2, xs, js, ks);
        pulse_start(2);
        send(-7, 10, 2, 0);
        send(4, -3, 5, 0);
        finish(int'(DSP_LAT) + 1, -82, 6, 1);

        // Input stall before the second element
        xs = '{3, -2, 5, 0, 0, 0, 0, 0};
        js = '{1, 2, 3, 0, 0, 0, 0, 0};
        ks = '{-4, 7, 0, 0, 0, 0, 0, 0};
        set_model(3, xs, js, ks);
        pulse_start(3);
        send(3, 1, -4, 0);
        send(-2, 2, 7, 1);
        send(5, 3, 0, 0);
        finish(int'(DSP_LAT) + 1, 14, -26, 0);

        // Async reset during WAIT of element 2 of 4
        exp_j = 0;
        exp_k = 0;
        pulse_start(4);
        send(1, 1, 1, 0);
        send(2, 2, 2, 0);
        in_valid = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 expect_zero_outputs("midrun_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Corner values after reset
        xs = '{-128, 0, 0, 0, 0, 0, 0, 0};
        js = '{-128, 0, 0, 0, 0, 0, 0, 0};
        ks = '{-128, 0, 0, 0, 0, 0, 0, 0};
        set_model(1, xs, js, ks);
        pulse_start(1);
        send(-128, -128, -128, 0);
        finish(int'(DSP_LAT) + 1, 16384, 16384, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
